// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared opcode encodings and sequencer state for decode and control
package isa_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_CALL  = 5'b11000;
  localparam logic [4:0] OP_CALL2 = 5'b11001;
  localparam logic [4:0] OP_RET   = 5'b11010;
  localparam logic [4:0] OP_RET2  = 5'b11011;
  localparam logic [4:0] OP_RTI   = 5'b11100;
  localparam logic [4:0] OP_RTI2  = 5'b11101;
  localparam logic [4:0] OP_INT1  = 5'b11110;
  localparam logic [4:0] OP_INT2  = 5'b11111;

  typedef enum logic [2:0] {
    ST_NORMAL = 3'd0,
    ST_CALL2  = 3'd1,
    ST_RET2   = 3'd2,
    ST_RTI2   = 3'd3,
    ST_INT2   = 3'd4
  } seq_state_t;

  // Second-part and interrupt encodings may only be produced by the sequencer itself.
  function automatic logic is_reserved(input logic [4:0] op);
    return (op == OP_CALL2) || (op == OP_RET2) || (op == OP_RTI2) ||
           (op == OP_INT1)  || (op == OP_INT2);
  endfunction

endpackage

// File: rtl/opcode_sequencer.sv
// rtl/opcode_sequencer.sv - decode-stage opcode sequencer: CALL/RET/RTI expansion and interrupt injection
module opcode_sequencer
  import isa_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] fetchOpCode,
  input  logic       fetchValid,
  input  logic       stall,
  input  logic       flush,
  input  logic       interrupt,
  output logic [4:0] opCode,
  output logic       fetchHold,
  output logic       intAck,
  output logic       illegalOp
);

  seq_state_t r_state;
  seq_state_t w_state_next;
  logic [4:0] r_opcode;
  logic       r_int_ack;
  logic       r_illegal;
  logic       r_pending;

  logic       w_take;
  logic       w_load;
  logic [4:0] w_op_next;
  logic       w_ack_next;
  logic       w_ill_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_NORMAL;
      r_opcode  <= OP_NOP;
      r_int_ack <= 1'b0;
      r_illegal <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      // A new pulse in the same cycle as the take keeps the request latched.
      r_pending <= interrupt | (r_pending & ~w_take);
      if (w_load) begin
        r_opcode  <= w_op_next;
        r_int_ack <= w_ack_next;
        r_illegal <= w_ill_next;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (flush) begin
          w_state_next = ST_NORMAL;
        end else if (!stall) begin
          if (r_pending) begin
            w_state_next = ST_INT2;
            w_take       = 1'b1;
          end else if (fetchValid) begin
            case (fetchOpCode)
              OP_CALL: w_state_next = ST_CALL2;
              OP_RET:  w_state_next = ST_RET2;
              OP_RTI:  w_state_next = ST_RTI2;
              default: w_state_next = ST_NORMAL;
            endcase
          end
        end
      end
      default: begin
        if (!stall) w_state_next = ST_NORMAL;
      end
    endcase
  end

  always_comb begin
    w_load     = 1'b0;
    w_op_next  = r_opcode;
    w_ack_next = 1'b0;
    w_ill_next = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (flush) begin
          w_load    = 1'b1;
          w_op_next = OP_NOP;
        end else if (!stall) begin
          w_load = 1'b1;
          if (r_pending) begin
            w_op_next  = OP_INT1;
            w_ack_next = 1'b1;
          end else if (!fetchValid) begin
            w_op_next = OP_NOP;
          end else if (is_reserved(fetchOpCode)) begin
            w_op_next  = OP_NOP;
            w_ill_next = 1'b1;
          end else begin
            w_op_next = fetchOpCode;
          end
        end
      end
      // Second parts ignore flush so a started pair is never split.
      ST_CALL2: begin w_load = ~stall; w_op_next = OP_CALL2; end
      ST_RET2:  begin w_load = ~stall; w_op_next = OP_RET2;  end
      ST_RTI2:  begin w_load = ~stall; w_op_next = OP_RTI2;  end
      ST_INT2:  begin w_load = ~stall; w_op_next = OP_INT2;  end
      default:  begin w_load = 1'b0;   w_op_next = r_opcode; end
    endcase
  end

  assign fetchHold = stall | (r_state != ST_NORMAL) |
                     ((r_state == ST_NORMAL) & r_pending & ~flush);
  assign opCode    = r_opcode;
  assign intAck    = r_int_ack;
  assign illegalOp = r_illegal;

endmodule

// File: tb/tb_opcode_sequencer.sv
// tb/tb_opcode_sequencer.sv - scoreboard bench for opcode_sequencer with directed vectors
module tb_opcode_sequencer;

  logic       clk;
  logic       rst_n;
  logic [4:0] fetchOpCode;
  logic       fetchValid;
  logic       stall;
  logic       flush;
  logic       interrupt;
  logic [4:0] opCode;
  logic       fetchHold;
  logic       intAck;
  logic       illegalOp;

  opcode_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetchOpCode (fetchOpCode),
    .fetchValid  (fetchValid),
    .stall       (stall),
    .flush       (flush),
    .interrupt   (interrupt),
    .opCode      (opCode),
    .fetchHold   (fetchHold),
    .intAck      (intAck),
    .illegalOp   (illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       hold;
    logic [4:0] op;
    logic       ack;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic hold_s;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%b required=%b", name, act, req);
  endtask

  // Inputs change at negedge; fetchHold sampled mid-low phase, registered outputs after posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1 hold_s = fetchHold;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".hold"}, {7'd0, hold_s}, {7'd0, e.hold});
        chk({e.name, ".op"},   {3'd0, opCode}, {3'd0, e.op});
        chk({e.name, ".ack"},  {7'd0, intAck}, {7'd0, e.ack});
        chk({e.name, ".ill"},  {7'd0, illegalOp}, {7'd0, e.ill});
      end
    end
  end

  task automatic step(input string name, input logic [4:0] f_op, input logic f_v,
                      input logic st, input logic fl, input logic irq,
                      input logic x_hold, input logic [4:0] x_op,
                      input logic x_ack, input logic x_ill);
    exp_t e;
    @(negedge clk);
    fetchOpCode = f_op;
    fetchValid  = f_v;
    stall       = st;
    flush       = fl;
    interrupt   = irq;
    e.name = name; e.hold = x_hold; e.op = x_op; e.ack = x_ack; e.ill = x_ill;
    exp_q.push_back(e);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; fetchOpCode = 5'd0; fetchValid = 1'b0;
    stall = 1'b0; flush = 1'b0; interrupt = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.op",   {3'd0, opCode}, 8'd0);
    chk("rst.ack",  {7'd0, intAck}, 8'd0);
    chk("rst.ill",  {7'd0, illegalOp}, 8'd0);
    chk("rst.hold", {7'd0, fetchHold}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //     name         fop       v  st fl irq  hold  op        ack ill
    step("call1",     5'b11000, 1, 0, 0, 0,   0, 5'b11000, 0, 0);
    step("call2",     5'b01001, 1, 0, 0, 0,   1, 5'b11001, 0, 0);
    step("call_nxt",  5'b01001, 1, 0, 0, 0,   0, 5'b01001, 0, 0);

    step("int_pulse", 5'b00000, 0, 0, 0, 1,   0, 5'b00000, 0, 0);
    step("int1",      5'b00100, 1, 0, 0, 0,   1, 5'b11110, 1, 0);
    step("int2",      5'b00100, 1, 0, 0, 0,   1, 5'b11111, 0, 0);
    step("int_res",   5'b00100, 1, 0, 0, 0,   0, 5'b00100, 0, 0);

    step("ret1",      5'b11010, 1, 0, 0, 1,   0, 5'b11010, 0, 0);
    step("ret2",      5'b01100, 1, 0, 0, 0,   1, 5'b11011, 0, 0);
    step("ret_int1",  5'b01100, 1, 0, 0, 0,   1, 5'b11110, 1, 0);
    step("ret_int2",  5'b01100, 1, 0, 0, 0,   1, 5'b11111, 0, 0);
    step("ret_res",   5'b01100, 1, 0, 0, 0,   0, 5'b01100, 0, 0);

    step("rti1",      5'b11100, 1, 0, 0, 0,   0, 5'b11100, 0, 0);
    step("rti_st1",   5'b00011, 1, 1, 0, 0,   1, 5'b11100, 0, 0);
    step("rti_st2",   5'b00011, 1, 1, 1, 0,   1, 5'b11100, 0, 0);
    step("rti_st3",   5'b00011, 1, 1, 0, 0,   1, 5'b11100, 0, 0);
    step("rti2_fl",   5'b00011, 1, 0, 1, 0,   1, 5'b11101, 0, 0);
    step("rti_nxt",   5'b00011, 1, 0, 0, 0,   0, 5'b00011, 0, 0);

    step("ill_11111", 5'b11111, 1, 0, 0, 0,   0, 5'b00000, 0, 1);
    step("flush",     5'b01001, 1, 0, 1, 0,   0, 5'b00000, 0, 0);
    step("ill_11101", 5'b11101, 1, 0, 0, 0,   0, 5'b00000, 0, 1);
    step("ill_stall", 5'b01010, 1, 1, 0, 0,   1, 5'b00000, 0, 1);
    step("ill_clr",   5'b01010, 1, 0, 0, 0,   0, 5'b01010, 0, 0);
    step("invalid",   5'b01111, 0, 0, 0, 0,   0, 5'b00000, 0, 0);

    step("fl_pulse",  5'b00000, 0, 0, 0, 1,   0, 5'b00000, 0, 0);
    step("fl_pend",   5'b01001, 1, 0, 1, 0,   0, 5'b00000, 0, 0);
    step("fl_int1",   5'b01001, 1, 0, 0, 0,   1, 5'b11110, 1, 0);
    step("fl_int2",   5'b01001, 1, 0, 0, 0,   1, 5'b11111, 0, 0);
    step("fl_res",    5'b01001, 1, 0, 0, 0,   0, 5'b01001, 0, 0);

    step("rcall1",    5'b11000, 1, 0, 0, 0,   0, 5'b11000, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    fetchValid = 1'b0;
    #1;
    chk("midrst.op",   {3'd0, opCode}, 8'd0);
    chk("midrst.hold", {7'd0, fetchHold}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("midrst_nxt", 5'b01001, 1, 0, 0, 0,  0, 5'b01001, 0, 0);
    step("idle",       5'b00000, 0, 0, 0, 0,  0, 5'b00000, 0, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
